// File: rtl/phase_timer.sv
// One-second prescaled phase countdown for the traffic controller; saturates at 1 (phase done).
// Optional emergency freeze (hold port, HOLD state) is built only when PHASE_TIMER_HOLD_EN is defined.
module phase_timer #(
  parameter int CLK_PER_SEC = 50000000,
  parameter int CNT_W       = 5,
  parameter int RST_VALUE   = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_counter,
  input  logic [CNT_W-1:0] load_value,
`ifdef PHASE_TIMER_HOLD_EN
  input  logic             hold,
`endif
  output logic [CNT_W-1:0] counter_value,
  output logic             sec_tick,
  output logic             expired,
  output logic [1:0]       state
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_PER_SEC - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_DONE = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  state_t           state_p0, state_nxt;
  logic [PW-1:0]    presc_p0, presc_nxt;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt;
  logic             expired_p0, expired_nxt;
  logic             hold_req;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v > ONE) ? (v - ONE) : ONE;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

`ifdef PHASE_TIMER_HOLD_EN
  assign hold_req = hold;
`else
  assign hold_req = 1'b0;
`endif

  assign sec_tick = (presc_p0 == PRESC_MAX) && (state_p0 != ST_HOLD);

  always_comb begin
    state_nxt   = state_p0;
    presc_nxt   = presc_p0;
    cnt_nxt     = cnt_p0;
    expired_nxt = 1'b0;
    if (load_counter) begin
      // A load beats a coincident tick: the prescaler restarts and no decrement happens.
      cnt_nxt     = clamp_load(load_value);
      presc_nxt   = '0;
      state_nxt   = (clamp_load(load_value) == ONE) ? ST_DONE : ST_RUN;
      expired_nxt = (load_value == '0);
    end else begin
      case (state_p0)
        ST_RUN: begin
          presc_nxt = sec_tick ? '0 : presc_p0 + PW'(1);
          if (sec_tick) begin
            cnt_nxt = sat_dec(cnt_p0);
            if (cnt_nxt == ONE) begin
              state_nxt   = ST_DONE;
              expired_nxt = (cnt_p0 == TWO);
            end
          end
        end
        ST_DONE: presc_nxt = sec_tick ? '0 : presc_p0 + PW'(1);
        ST_HOLD: begin
          if (!hold_req) state_nxt = (cnt_p0 == ONE) ? ST_DONE : ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
    if (hold_req) state_nxt = ST_HOLD;
    // expired is a single pulse and never shows while frozen.
    if ((state_nxt == ST_HOLD) || expired_p0) expired_nxt = 1'b0;
  end

  // Stage p0: timer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= ST_RUN;
      presc_p0   <= '0;
      cnt_p0     <= CNT_W'(RST_VALUE);
      expired_p0 <= 1'b0;
    end else begin
      state_p0   <= state_nxt;
      presc_p0   <= presc_nxt;
      cnt_p0     <= cnt_nxt;
      expired_p0 <= expired_nxt;
    end
  end

  assign counter_value = cnt_p0;
  assign expired       = expired_p0;
  assign state         = state_p0;

endmodule

// File: tb/tb_phase_timer.sv
// Randomized and directed bench for phase_timer (CLK_PER_SEC=4) against a cycle-level reference model.
module tb_phase_timer;
  localparam int CPS = 4;
  localparam int CW  = 5;
  localparam int RV  = 30;
`ifdef PHASE_TIMER_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          load_counter;
  logic [CW-1:0] load_value;
  logic          hold;
  logic [CW-1:0] counter_value;
  logic          sec_tick;
  logic          expired;
  logic [1:0]    state;

  int checks   = 0;
  int failures = 0;

  // Reference model: count, phase within the current second, frozen flag, pending expired pulse.
  int m_cnt;
  int m_phase;
  bit m_hold;
  bit m_exp;

  phase_timer #(.CLK_PER_SEC(CPS), .CNT_W(CW), .RST_VALUE(RV)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_counter (load_counter),
    .load_value   (load_value),
`ifdef PHASE_TIMER_HOLD_EN
    .hold         (hold),
`endif
    .counter_value(counter_value),
    .sec_tick     (sec_tick),
    .expired      (expired),
    .state        (state)
  );

  always #5 clk = ~clk;

  function automatic int m_state();
    if (m_hold) return 2;
    return (m_cnt == 1) ? 1 : 0;
  endfunction

  function automatic bit m_tick();
    return !m_hold && (m_phase == CPS - 1);
  endfunction

  task automatic model_edge();
    bit tick;
    bit prev;
    bit fire;
    tick = m_tick();
    prev = m_exp;
    fire = 1'b0;
    if (rst) begin
      m_cnt = RV; m_phase = 0; m_hold = 1'b0; m_exp = 1'b0;
    end else begin
      if (load_counter) begin
        m_cnt   = (load_value == 0) ? 1 : int'(load_value);
        m_phase = 0;
        fire    = (load_value == 0);
      end else if (!m_hold) begin
        if (tick && m_cnt > 1) begin
          fire  = (m_cnt == 2);
          m_cnt = m_cnt - 1;
        end
        m_phase = (m_phase + 1) % CPS;
      end
      m_hold = HOLD_EN && hold;
      m_exp  = fire && !m_hold && !prev;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; load_counter = 1'b0; load_value = '0; hold = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_counter = 1'b1; load_value = 5'd7; hold = HOLD_EN;
    step();
    idle();
    checks++; if (counter_value !== 5'd30) begin failures++; $display("FAIL reset_count got=%0d exp=30", counter_value); end
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%0b exp=00", state); end
    checks++; if (sec_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", sec_tick); end
    checks++; if (expired !== 1'b0) begin failures++; $display("FAIL reset_expired got=%b exp=0", expired); end
  endtask

  task automatic test_self_start();
    int ticks = 0;
    int pulses = 0;
    idle();
    for (int i = 1; i <= 116; i++) begin
      step();
      if (sec_tick === 1'b1) ticks++;
      if (expired === 1'b1) pulses++;
      checks++;
      if (counter_value !== CW'(m_cnt) || sec_tick !== m_tick() || expired !== m_exp) begin
        failures++;
        $display("FAIL self_start cyc=%0d got cnt=%0d tick=%b exp=%b want cnt=%0d tick=%b exp=%b",
                 i, counter_value, sec_tick, expired, m_cnt, m_tick(), m_exp);
      end
    end
    checks++; if (counter_value !== 5'd1) begin failures++; $display("FAIL self_start_final got=%0d exp=1", counter_value); end
    checks++; if (ticks != 29) begin failures++; $display("FAIL self_start_ticks got=%0d exp=29", ticks); end
    checks++; if (pulses != 1 || expired !== 1'b1) begin failures++; $display("FAIL self_start_expired pulses=%0d last=%b exp 1/1", pulses, expired); end
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (counter_value !== 5'd1 || state !== 2'b01 || expired !== 1'b0) begin
      failures++; $display("FAIL done_hold got cnt=%0d st=%0b exp=%b want 1/01/0", counter_value, state, expired);
    end
  endtask

  task automatic test_orange();
    load_counter = 1'b1; load_value = 5'd3;
    step();
    idle();
    checks++; if (counter_value !== 5'd3 || state !== 2'b00) begin failures++; $display("FAIL orange_load got cnt=%0d st=%0b want 3/00", counter_value, state); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (counter_value !== 5'd2) begin failures++; $display("FAIL orange_2 got=%0d exp=2", counter_value); end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (counter_value !== 5'd1 || expired !== 1'b1 || state !== 2'b01) begin
      failures++; $display("FAIL orange_1 got cnt=%0d exp=%b st=%0b want 1/1/01", counter_value, expired, state);
    end
  endtask

  task automatic test_collision();
    int n = 0;
    load_counter = 1'b1; load_value = 5'd9;
    step();
    idle();
    while (sec_tick !== 1'b1 && n < 8) begin step(); n++; end
    checks++;
    if (sec_tick !== 1'b1) begin
      failures++; $display("FAIL collision_wait got tick=%b exp=1 within 8 cycles", sec_tick);
    end else begin
      load_counter = 1'b1; load_value = 5'd30;
      step();
      idle();
      checks++; if (counter_value !== 5'd30) begin failures++; $display("FAIL collision_count got=%0d exp=30", counter_value); end
      checks++; if (sec_tick !== 1'b0) begin failures++; $display("FAIL collision_tick0 got=%b exp=0", sec_tick); end
      for (int i = 0; i < 3; i++) step();
      checks++; if (sec_tick !== 1'b1) begin failures++; $display("FAIL collision_next_tick got=%b exp=1", sec_tick); end
    end
  endtask

  task automatic test_load_zero();
    load_counter = 1'b1; load_value = 5'd0;
    step();
    idle();
    checks++;
    if (counter_value !== 5'd1 || state !== 2'b01 || expired !== 1'b1) begin
      failures++; $display("FAIL load_zero got cnt=%0d st=%0b exp=%b want 1/01/1", counter_value, state, expired);
    end
    step();
    checks++; if (expired !== 1'b0) begin failures++; $display("FAIL load_zero_pulse got=%b exp=0", expired); end
  endtask

  task automatic test_back_to_back();
    load_counter = 1'b1; load_value = 5'd0;
    step();
    checks++; if (expired !== 1'b1) begin failures++; $display("FAIL b2b_first got=%b exp=1", expired); end
    step();
    idle();
    checks++; if (expired !== 1'b0) begin failures++; $display("FAIL b2b_second got=%b exp=0", expired); end
  endtask

`ifdef PHASE_TIMER_HOLD_EN
  task automatic test_hold();
    int n = 0;
    load_counter = 1'b1; load_value = 5'd5;
    step();
    idle();
    step(); step();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (counter_value !== 5'd5 || sec_tick !== 1'b0 || state !== 2'b10) begin
        failures++; $display("FAIL hold_freeze cyc=%0d got cnt=%0d tick=%b st=%0b want 5/0/10", i, counter_value, sec_tick, state);
      end
    end
    hold = 1'b0;
    while (counter_value === 5'd5 && n < 8) begin step(); n++; end
    checks++;
    if (counter_value !== 5'd4 || n != 2) begin
      failures++; $display("FAIL hold_resume got cnt=%0d after %0d cycles want 4 after 2", counter_value, n);
    end
  endtask

  task automatic test_reset_in_hold();
    hold = 1'b1;
    step();
    rst = 1'b1; load_counter = 1'b1; load_value = 5'd3;
    step();
    idle();
    checks++;
    if (state !== 2'b00 || counter_value !== 5'd30) begin
      failures++; $display("FAIL reset_in_hold got st=%0b cnt=%0d want 00/30", state, counter_value);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      load_counter = ($urandom_range(0, 7) == 0);
      load_value   = ($urandom_range(0, 1) == 0) ? CW'($urandom_range(0, 3)) : CW'($urandom);
      if (HOLD_EN && $urandom_range(0, 9) == 0) hold = ~hold;
      step();
      checks++;
      if (counter_value !== CW'(m_cnt) || state !== 2'(m_state()) ||
          sec_tick !== m_tick() || expired !== m_exp) begin
        failures++;
        $display("FAIL random cyc=%0d got cnt=%0d st=%0d tick=%b exp=%b want cnt=%0d st=%0d tick=%b exp=%b",
                 i, counter_value, state, sec_tick, expired, m_cnt, m_state(), m_tick(), m_exp);
      end
    end
    idle();
  endtask

  initial begin
    m_cnt = RV; m_phase = 0; m_hold = 1'b0; m_exp = 1'b0;
    idle();
    test_reset();
    test_self_start();
    test_orange();
    test_collision();
    test_load_zero();
    test_back_to_back();
`ifdef PHASE_TIMER_HOLD_EN
    test_hold();
    test_reset_in_hold();
`endif
    test_random();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
